// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, glyph table and decoder for the 7-segment capture monitor
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [6:0] BLANK_CODE = 7'h7F;

    // Active-low A..G patterns; element i is the glyph for hex digit i.
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Returns {valid, blank, nibble}; an unknown pattern is reported as not valid and blank.
    function automatic logic [5:0] seg_decode(input logic [6:0] i_seg);
        logic [5:0] w_res;
        w_res = (i_seg == BLANK_CODE) ? 6'b11_0000 : 6'b01_0000;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == GLYPH[i]) begin
                w_res = {2'b10, 4'(i)};
            end
        end
        return w_res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a configurable per-bit reset value
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= {WIDTH{RESET_VAL}};
            r_sync <= {WIDTH{RESET_VAL}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - reconstructs per-digit values from a multiplexed active-low
// 7-segment bus and flags scan protocol and glyph errors
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_SEGMENTS  = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_SEGMENTS-1:0]   i_anode,
    input  logic [7:0]                i_cathode,
    output logic [NUM_SEGMENTS*4-1:0] o_digit_value,
    output logic [NUM_SEGMENTS-1:0]   o_digit_dp,
    output logic [NUM_SEGMENTS-1:0]   o_digit_blank,
    output logic                      o_frame_done,
    output logic                      o_code_err,
    output logic                      o_multi_err
);

    localparam logic [7:0]              LP_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [NUM_SEGMENTS-1:0] LP_ONE         = {{(NUM_SEGMENTS-1){1'b0}}, 1'b1};

    logic [NUM_SEGMENTS-1:0]   w_a_s;
    logic [7:0]                w_c_s;
    logic [NUM_SEGMENTS-1:0]   w_low;
    logic                      w_multi;
    logic                      w_single;
    logic                      w_a_changed;
    logic [5:0]                w_dec;
    logic [NUM_SEGMENTS-1:0]   w_mask_new;

    state_t                    r_state;
    logic [7:0]                r_cnt;
    logic [NUM_SEGMENTS-1:0]   r_a_cur;
    logic [NUM_SEGMENTS-1:0]   r_mask;
    logic [NUM_SEGMENTS*4-1:0] r_value;
    logic [NUM_SEGMENTS-1:0]   r_dp;
    logic [NUM_SEGMENTS-1:0]   r_blank;
    logic                      r_frame_done;
    logic                      r_code_err;
    logic                      r_multi_err;

    sync_2ff #(.WIDTH(NUM_SEGMENTS), .RESET_VAL(1'b1)) u_sync_anode (
        .i_clk (i_clk),
        .i_rst (i_reset),
        .i_d   (i_anode),
        .o_q   (w_a_s)
    );

    sync_2ff #(.WIDTH(8), .RESET_VAL(1'b1)) u_sync_cathode (
        .i_clk (i_clk),
        .i_rst (i_reset),
        .i_d   (i_cathode),
        .o_q   (w_c_s)
    );

    assign w_low       = ~w_a_s;
    assign w_multi     = (w_low & (w_low - LP_ONE)) != '0;
    assign w_single    = (w_low != '0) && !w_multi;
    // r_a_cur starts all ones, so only a real departure from the idle bus is evaluated.
    assign w_a_changed = (w_a_s != r_a_cur);
    assign w_dec       = seg_decode(w_c_s[6:0]);
    assign w_mask_new  = r_mask | ~r_a_cur;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_a_cur      <= '1;
            r_mask       <= '0;
            r_value      <= '0;
            r_dp         <= '0;
            r_blank      <= '1;
            r_frame_done <= 1'b0;
            r_code_err   <= 1'b0;
            r_multi_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_code_err   <= 1'b0;
            r_multi_err  <= 1'b0;
            if (r_state != ST_CAPTURE && w_a_changed) begin
                // A new selection always wins, including over a pending terminal count.
                r_a_cur <= w_a_s;
                r_cnt   <= LP_SETTLE_LOAD;
                if (w_multi) begin
                    r_multi_err <= 1'b1;
                    r_state     <= ST_IDLE;
                end else if (w_single) begin
                    r_state <= ST_SETTLE;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (r_cnt == 8'd0) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        for (int i = 0; i < NUM_SEGMENTS; i++) begin
                            if (!r_a_cur[i]) begin
                                r_dp[i]    <= ~w_c_s[7];
                                r_blank[i] <= w_dec[4];
                                if (!w_dec[4]) begin
                                    r_value[i*4 +: 4] <= w_dec[3:0];
                                end
                            end
                        end
                        r_code_err <= ~w_dec[5];
                        if (&w_mask_new) begin
                            r_mask       <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_mask <= w_mask_new;
                        end
                        r_state <= ST_HOLD;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_digit_value = r_value;
    assign o_digit_dp    = r_dp;
    assign o_digit_blank = r_blank;
    assign o_frame_done  = r_frame_done;
    assign o_code_err    = r_code_err;
    assign o_multi_err   = r_multi_err;

endmodule
